// File: rtl/seq_alu.sv
// Registered ALU with a start/busy/done handshake. Single-cycle ops complete on
// the acceptance edge; rotates step one bit per cycle and MUL runs W shift-add steps.
`timescale 1ns/1ps
module seq_alu #(
    parameter int W    = 8,
    parameter int CMDW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [CMDW-1:0] alu_cmd,
    input  logic [W-1:0]    rd_A,
    input  logic [W-1:0]    rd_B,
    input  logic            sc_i,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    rslt,
    output logic            sc_o,
    output logic            pari,
    output logic            zero
);
    localparam int LW = $clog2(W);
    localparam int CW = LW + 1;

    localparam logic [CMDW-1:0] OP_ADD = CMDW'(0);
    localparam logic [CMDW-1:0] OP_AND = CMDW'(1);
    localparam logic [CMDW-1:0] OP_XOR = CMDW'(2);
    localparam logic [CMDW-1:0] OP_SUB = CMDW'(3);
    localparam logic [CMDW-1:0] OP_MOV = CMDW'(4);
    localparam logic [CMDW-1:0] OP_ROL = CMDW'(5);
    localparam logic [CMDW-1:0] OP_ROR = CMDW'(6);
    localparam logic [CMDW-1:0] OP_MUL = CMDW'(7);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    function automatic logic [W-1:0] rol1(input logic [W-1:0] x);
        return {x[W-2:0], x[W-1]};
    endfunction

    function automatic logic [W-1:0] ror1(input logic [W-1:0] x);
        return {x[0], x[W-1:1]};
    endfunction

    function automatic logic parity(input logic [W-1:0] x);
        return ^x;
    endfunction

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CMDW-1:0]   op_q, op_d;
    logic [W-1:0]      work_q, work_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic [2*W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]      mplier_q, mplier_d;
    logic              done_q, done_d;
    logic [W-1:0]      rslt_q, rslt_d;
    logic              sc_q, sc_d;
    logic              pari_q, pari_d;
    logic              zero_q, zero_d;

    logic [LW-1:0]     sh_s;
    logic [W:0]        sum_s;
    logic [2*W-1:0]    acc_n_s;
    logic              fin_s;
    logic [W-1:0]      fin_r_s;
    logic              fin_c_s;

    // State, iteration and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= {CMDW{1'b0}};
            work_q   <= {W{1'b0}};
            acc_q    <= {(2*W){1'b0}};
            mcand_q  <= {(2*W){1'b0}};
            mplier_q <= {W{1'b0}};
            done_q   <= 1'b0;
            rslt_q   <= {W{1'b0}};
            sc_q     <= 1'b0;
            pari_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            work_q   <= work_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            done_q   <= done_d;
            rslt_q   <= rslt_d;
            sc_q     <= sc_d;
            pari_q   <= pari_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state, iteration step and final-result selection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        work_d   = work_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done_d   = 1'b0;
        rslt_d   = rslt_q;
        sc_d     = sc_q;
        pari_d   = pari_q;
        zero_d   = zero_q;
        fin_s    = 1'b0;
        fin_r_s  = {W{1'b0}};
        fin_c_s  = 1'b0;
        sh_s     = rd_B[LW-1:0];
        sum_s    = {1'b0, rd_A} + {1'b0, rd_B} + {{W{1'b0}}, sc_i};
        acc_n_s  = acc_q + (mplier_q[0] ? mcand_q : {(2*W){1'b0}});

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = alu_cmd;
                    case (alu_cmd)
                        OP_ADD: begin fin_s = 1'b1; fin_r_s = sum_s[W-1:0]; fin_c_s = sum_s[W]; end
                        OP_AND: begin fin_s = 1'b1; fin_r_s = rd_A & rd_B; end
                        OP_XOR: begin
                            fin_s = 1'b1;
                            if (rd_A == rd_B) begin
                                fin_r_s = {{(W-1){1'b0}}, parity(rd_A)};
                            end else begin
                                fin_r_s = rd_A ^ rd_B;
                            end
                        end
                        OP_SUB: begin fin_s = 1'b1; fin_r_s = rd_A - rd_B; fin_c_s = (rd_A < rd_B); end
                        OP_MOV: begin fin_s = 1'b1; fin_r_s = rd_B; end
                        OP_ROL, OP_ROR: begin
                            if (sh_s == {LW{1'b0}}) begin
                                fin_s   = 1'b1;
                                fin_r_s = rd_A;
                            end else if (sh_s == LW'(1)) begin
                                fin_s   = 1'b1;
                                fin_r_s = (alu_cmd == OP_ROL) ? rol1(rd_A) : ror1(rd_A);
                                fin_c_s = (alu_cmd == OP_ROL) ? rd_A[W-1] : rd_A[0];
                            end else begin
                                // First rotation happens on the acceptance edge; cnt_q counts the RUN edges left.
                                work_d  = (alu_cmd == OP_ROL) ? rol1(rd_A) : ror1(rd_A);
                                cnt_d   = {1'b0, sh_s} - CW'(1);
                                state_d = S_RUN;
                            end
                        end
                        OP_MUL: begin
                            acc_d    = rd_B[0] ? {{W{1'b0}}, rd_A} : {(2*W){1'b0}};
                            mcand_d  = {{(W-1){1'b0}}, rd_A, 1'b0};
                            mplier_d = {1'b0, rd_B[W-1:1]};
                            cnt_d    = CW'(W - 1);
                            state_d  = S_RUN;
                        end
                        default: begin fin_s = 1'b1; end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                case (op_q)
                    OP_ROL, OP_ROR: begin
                        if (cnt_q == CW'(1)) begin
                            fin_s   = 1'b1;
                            fin_r_s = (op_q == OP_ROL) ? rol1(work_q) : ror1(work_q);
                            fin_c_s = (op_q == OP_ROL) ? work_q[W-1] : work_q[0];
                            state_d = S_IDLE;
                        end else begin
                            work_d = (op_q == OP_ROL) ? rol1(work_q) : ror1(work_q);
                            cnt_d  = cnt_q - CW'(1);
                        end
                    end
                    OP_MUL: begin
                        if (cnt_q == CW'(1)) begin
                            fin_s   = 1'b1;
                            fin_r_s = acc_n_s[W-1:0];
                            fin_c_s = |acc_n_s[2*W-1:W];
                            state_d = S_IDLE;
                        end else begin
                            acc_d    = acc_n_s;
                            mcand_d  = {mcand_q[2*W-2:0], 1'b0};
                            mplier_d = {1'b0, mplier_q[W-1:1]};
                            cnt_d    = cnt_q - CW'(1);
                        end
                    end
                    default: begin state_d = S_IDLE; end
                endcase
            end
            default: begin state_d = S_IDLE; end
        endcase

        if (fin_s) begin
            done_d = 1'b1;
            rslt_d = fin_r_s;
            sc_d   = fin_c_s;
            pari_d = parity(fin_r_s);
            zero_d = (fin_r_s == {W{1'b0}});
        end else begin
            done_d = 1'b0;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign rslt = rslt_q;
    assign sc_o = sc_q;
    assign pari = pari_q;
    assign zero = zero_q;
endmodule
